// File: rtl/knn_ctrl_if.sv
// Control/handshake bundle between knn_ctrl and the KNN datapath, memories
// and result consumer. The controller drives through the master modport.
interface knn_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int TIDX_W = 2
);
   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] test_addr;
   logic [ADDR_W-1:0] data_addr;
   logic              dist_clr;
   logic              dist_en;
   logic              dist_valid;
   logic              list_clr;
   logic              list_insert;
   logic              res_valid;
   logic              res_ready;
   logic [TIDX_W-1:0] res_test_idx;

   modport master (
      input  start, abort, res_ready,
      output busy, done, rd_en, test_addr, data_addr, dist_clr, dist_en,
             dist_valid, list_clr, list_insert, res_valid, res_test_idx
   );

   modport slave (
      output start, abort, res_ready,
      input  busy, done, rd_en, test_addr, data_addr, dist_clr, dist_en,
             dist_valid, list_clr, list_insert, res_valid, res_test_idx
   );
endinterface

// File: rtl/knn_ctrl.sv
// KNN sequencer: walks every test point against every data point, steering
// the distance unit and neighbour list, and hands each finished list to the
// result consumer over a valid/ready handshake.
module knn_ctrl #(
   parameter int DATA_W    = 32,
   parameter int NBR_KNN   = 4,
   parameter int NBR_TESTP = 4,
   parameter int NBR_DATAP = 10,
   parameter int NBR_DIM   = 2,
   parameter int ADDR_W    =
      ($clog2(((NBR_TESTP > NBR_DATAP) ? NBR_TESTP : NBR_DATAP) * NBR_DIM) < 1) ? 1 :
       $clog2(((NBR_TESTP > NBR_DATAP) ? NBR_TESTP : NBR_DATAP) * NBR_DIM),
   parameter int TIDX_W    = (NBR_TESTP > 1) ? $clog2(NBR_TESTP) : 1
) (
   input logic        clk,
   input logic        rst,
   knn_ctrl_if.master bus
);

   localparam int DIDX_W = (NBR_DATAP > 1) ? $clog2(NBR_DATAP) : 1;
   localparam int CRD_W  = (NBR_DIM > 1) ? $clog2(NBR_DIM) : 1;

   localparam logic [TIDX_W-1:0] TEST_LAST  = TIDX_W'(NBR_TESTP - 1);
   localparam logic [DIDX_W-1:0] DATA_LAST  = DIDX_W'(NBR_DATAP - 1);
   localparam logic [CRD_W-1:0]  COORD_LAST = CRD_W'(NBR_DIM - 1);
   localparam logic [TIDX_W-1:0] TEST_ONE   = TIDX_W'(1);
   localparam logic [DIDX_W-1:0] DATA_ONE   = DIDX_W'(1);
   localparam logic [CRD_W-1:0]  COORD_ONE  = CRD_W'(1);

   // Data width and list depth only travel alongside this block; reject nonsense values.
   if (DATA_W < 1 || NBR_KNN < 1 || NBR_TESTP < 1 || NBR_DATAP < 1 || NBR_DIM < 1) begin : g_bad_param
      $error("knn_ctrl: all size parameters must be positive");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_TCLR, S_DCLR, S_RD, S_LAST, S_INS, S_OUT, S_DONE
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic [TIDX_W-1:0] test_idx_r;
   logic [DIDX_W-1:0] data_idx_r;
   logic [CRD_W-1:0]  coord_r;

   logic busy_r, done_r, rd_en_r, dist_clr_r, dist_valid_r;
   logic list_clr_r, list_insert_r, res_valid_r;

   // Next-state decode; abort overrides every state, including a start in IDLE.
   always_comb begin
      state_nx_s = state_r;
      if (bus.abort) begin
         state_nx_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE:  state_nx_s = bus.start ? S_TCLR : S_IDLE;
            S_TCLR:  state_nx_s = S_DCLR;
            S_DCLR:  state_nx_s = S_RD;
            S_RD:    state_nx_s = (coord_r == COORD_LAST) ? S_LAST : S_RD;
            S_LAST:  state_nx_s = S_INS;
            S_INS:   state_nx_s = (data_idx_r == DATA_LAST) ? S_OUT : S_DCLR;
            S_OUT: begin
               if (bus.res_ready) begin
                  state_nx_s = (test_idx_r == TEST_LAST) ? S_DONE : S_TCLR;
               end else begin
                  state_nx_s = S_OUT;
               end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Loop counters; everything returns to zero whenever the sequencer goes idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         test_idx_r <= '0;
         data_idx_r <= '0;
         coord_r    <= '0;
      end else if (state_nx_s == S_IDLE) begin
         test_idx_r <= '0;
         data_idx_r <= '0;
         coord_r    <= '0;
      end else begin
         case (state_r)
            S_TCLR: begin
               data_idx_r <= '0;
               coord_r    <= '0;
            end
            S_RD: begin
               if (coord_r != COORD_LAST) begin
                  coord_r <= coord_r + COORD_ONE;
               end
            end
            S_INS: begin
               coord_r <= '0;
               if (data_idx_r != DATA_LAST) begin
                  data_idx_r <= data_idx_r + DATA_ONE;
               end
            end
            S_OUT: begin
               if (bus.res_ready && (test_idx_r != TEST_LAST)) begin
                  test_idx_r <= test_idx_r + TEST_ONE;
               end
            end
            default: begin
               test_idx_r <= test_idx_r;
            end
         endcase
      end
   end

   // Strobes are registered from the next state so each one lines up with its state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         rd_en_r       <= 1'b0;
         dist_clr_r    <= 1'b0;
         dist_valid_r  <= 1'b0;
         list_clr_r    <= 1'b0;
         list_insert_r <= 1'b0;
         res_valid_r   <= 1'b0;
      end else begin
         busy_r        <= (state_nx_s != S_IDLE);
         done_r        <= (state_nx_s == S_DONE);
         rd_en_r       <= (state_nx_s == S_RD);
         dist_clr_r    <= (state_nx_s == S_DCLR);
         dist_valid_r  <= (state_r == S_RD) && (state_nx_s != S_IDLE);
         list_clr_r    <= (state_nx_s == S_TCLR);
         list_insert_r <= (state_nx_s == S_INS);
         res_valid_r   <= (state_nx_s == S_OUT);
      end
   end

   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.rd_en        = rd_en_r;
   assign bus.dist_clr     = dist_clr_r;
   assign bus.dist_en      = busy_r;
   assign bus.dist_valid   = dist_valid_r;
   assign bus.list_clr     = list_clr_r;
   assign bus.list_insert  = list_insert_r;
   assign bus.res_valid    = res_valid_r;
   assign bus.res_test_idx = test_idx_r;
   assign bus.test_addr    = ADDR_W'(int'(test_idx_r) * NBR_DIM + int'(coord_r));
   assign bus.data_addr    = ADDR_W'(int'(data_idx_r) * NBR_DIM + int'(coord_r));

endmodule

// File: tb/tb_knn_ctrl.sv
// Directed bench for knn_ctrl with default sizing (4 test, 10 data, 2 dims).
module tb_knn_ctrl;
   localparam int ADDR_W = 5;
   localparam int TIDX_W = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   int cnt_busy, cnt_rd, cnt_ins, cnt_dclr, cnt_lclr, cnt_res;
   int done_n, last_out_n, seq_err;

   knn_ctrl_if #(.ADDR_W(ADDR_W), .TIDX_W(TIDX_W)) dut_if ();

   knn_ctrl #(
      .DATA_W(32), .NBR_KNN(4), .NBR_TESTP(4), .NBR_DATAP(10), .NBR_DIM(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] strobes();
      return 32'({dut_if.busy, dut_if.done, dut_if.rd_en, dut_if.dist_clr, dut_if.dist_en,
                  dut_if.dist_valid, dut_if.list_clr, dut_if.list_insert, dut_if.res_valid});
   endfunction

   // Pulse start for one cycle; returns at the first negedge after it was sampled.
   task automatic pulse_start();
      dut_if.start = 1'b1;
      @(negedge clk);
      dut_if.start = 1'b0;
   endtask

   // Observe a run from its first busy cycle to done, with an optional stray start.
   task automatic run_count(input int stray_start_at);
      int  rd_seen;
      logic prev_rd;
      cnt_busy = 0; cnt_rd = 0; cnt_ins = 0; cnt_dclr = 0; cnt_lclr = 0; cnt_res = 0;
      done_n = 0; last_out_n = 0; seq_err = 0; rd_seen = 0; prev_rd = 1'b0;
      for (int n = 1; n <= 400 && done_n == 0; n++) begin
         if (n > 1) @(negedge clk);
         dut_if.start = (n == stray_start_at);
         if (dut_if.busy)        cnt_busy++;
         if (dut_if.list_insert) cnt_ins++;
         if (dut_if.dist_clr)    cnt_dclr++;
         if (dut_if.list_clr)    cnt_lclr++;
         if (dut_if.rd_en) begin
            cnt_rd++;
            if (rd_seen >= 20 && rd_seen < 40) begin
               if (dut_if.data_addr != ADDR_W'(rd_seen - 20))    seq_err++;
               if (dut_if.test_addr != ADDR_W'(2 + rd_seen % 2)) seq_err++;
            end
            rd_seen++;
         end
         if (dut_if.dist_valid != prev_rd) seq_err++;
         prev_rd = dut_if.rd_en;
         if (dut_if.res_valid) begin
            if (dut_if.res_test_idx != TIDX_W'(cnt_res)) seq_err++;
            cnt_res++;
            last_out_n = n;
         end
         if (dut_if.done) done_n = n;
      end
      dut_if.start = 1'b0;
   endtask

   initial begin
      int k;
      int ins;
      int hold_err;
      int done_err;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      dut_if.start = 1'b0;
      dut_if.abort = 1'b0;
      dut_if.res_ready = 1'b1;

      // Power-on reset
      repeat (3) @(negedge clk);
      check_eq("rst_strobes", strobes(), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rel_busy", 32'(dut_if.busy), 32'd0);
      check_eq("rel_taddr", 32'(dut_if.test_addr), 32'd0);
      check_eq("rel_daddr", 32'(dut_if.data_addr), 32'd0);

      // Nominal run, consumer always ready
      pulse_start();
      check_eq("start_busy", 32'(dut_if.busy), 32'd1);
      check_eq("start_lclr", 32'(dut_if.list_clr), 32'd1);
      run_count(0);
      check_eq("nom_done_n", 32'(done_n), 32'd209);
      check_eq("nom_done_after_out", 32'(done_n), 32'(last_out_n + 1));
      check_eq("nom_busy_cycles", 32'(cnt_busy), 32'd209);
      check_eq("nom_res", 32'(cnt_res), 32'd4);
      check_eq("nom_ins", 32'(cnt_ins), 32'd40);
      check_eq("nom_rd", 32'(cnt_rd), 32'd80);
      check_eq("nom_dclr", 32'(cnt_dclr), 32'd40);
      check_eq("nom_lclr", 32'(cnt_lclr), 32'd4);
      check_eq("nom_seq_err", 32'(seq_err), 32'd0);
      @(negedge clk);
      check_eq("post_done", 32'({dut_if.done, dut_if.busy}), 32'd0);

      // Backpressure in OUT of test 0
      dut_if.res_ready = 1'b0;
      pulse_start();
      k = 0;
      while (!dut_if.res_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_eq("bp_reach_out", 32'(dut_if.res_valid), 32'd1);
      hold_err = 0;
      for (int i = 0; i < 7; i++) begin
         if (!dut_if.res_valid || dut_if.res_test_idx != TIDX_W'(0) ||
             dut_if.rd_en || dut_if.list_clr) hold_err++;
         @(negedge clk);
      end
      check_eq("bp_hold_err", 32'(hold_err), 32'd0);
      check_eq("bp_still_valid", 32'(dut_if.res_valid), 32'd1);
      dut_if.res_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_hs_valid", 32'(dut_if.res_valid), 32'd0);
      check_eq("bp_hs_lclr", 32'(dut_if.list_clr), 32'd1);
      check_eq("bp_hs_idx", 32'(dut_if.res_test_idx), 32'd1);

      // Abort in INS of test 2, data point 5 (26th insert of the run)
      ins = 10;
      k = 0;
      while (k < 300) begin
         @(negedge clk);
         k++;
         if (dut_if.list_insert) begin
            ins++;
            if (ins == 26) break;
         end
      end
      check_eq("ab_ins_count", 32'(ins), 32'd26);
      check_eq("ab_idx", 32'(dut_if.res_test_idx), 32'd2);
      check_eq("ab_daddr", 32'(dut_if.data_addr), 32'd11);
      check_eq("ab_taddr", 32'(dut_if.test_addr), 32'd5);
      dut_if.abort = 1'b1;
      @(negedge clk);
      dut_if.abort = 1'b0;
      check_eq("ab_strobes", strobes(), 32'd0);
      check_eq("ab_daddr0", 32'(dut_if.data_addr), 32'd0);
      check_eq("ab_idx0", 32'(dut_if.res_test_idx), 32'd0);
      done_err = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (dut_if.done || dut_if.busy) done_err++;
      end
      check_eq("ab_no_done", 32'(done_err), 32'd0);

      // start together with abort in IDLE is ignored
      dut_if.start = 1'b1;
      dut_if.abort = 1'b1;
      @(negedge clk);
      dut_if.start = 1'b0;
      dut_if.abort = 1'b0;
      check_eq("sa_strobes", strobes(), 32'd0);

      // Fresh run from test 0 with a stray start while busy
      pulse_start();
      check_eq("re_lclr", 32'(dut_if.list_clr), 32'd1);
      check_eq("re_idx", 32'(dut_if.res_test_idx), 32'd0);
      run_count(3);
      check_eq("re_done_n", 32'(done_n), 32'd209);
      check_eq("re_rd", 32'(cnt_rd), 32'd80);
      check_eq("re_res", 32'(cnt_res), 32'd4);
      check_eq("re_seq_err", 32'(seq_err), 32'd0);

      // Asynchronous reset while reading
      @(negedge clk);
      pulse_start();
      k = 0;
      while (!dut_if.rd_en && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("mr_in_rd", 32'(dut_if.rd_en), 32'd1);
      rst = 1'b0;
      #1;
      check_eq("mr_strobes", strobes(), 32'd0);
      check_eq("mr_taddr", 32'(dut_if.test_addr), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mr_rel_busy", 32'(dut_if.busy), 32'd0);
      check_eq("mr_rel_daddr", 32'(dut_if.data_addr), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
